// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one registered grant of a shared resource among NUM_REQ requesters.
// Latency: one cycle from request to grant; back-to-back grants on a handshake, no bubble.
// Backpressure: a held grant stays frozen until res_ready_i completes the handshake.
//
// Ports:
//   clk_i, rst_ni  - clock and synchronous active-low reset
//   req_i          - request vector, bit k = requester k wants the resource
//   gnt_o          - registered one-hot grant (zero when idle)
//   gnt_idx_o      - registered binary index of the granted requester
//   gnt_valid_o    - high while a grant is held (valid towards the resource)
//   res_ready_i    - resource ready; valid & ready = handshake
//   gnt_count_o    - number of completed handshakes since reset (wraps)
module rr_arbiter #(
   parameter  int NUM_REQ = 16,
   parameter  int CNT_W   = 16,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_REQ-1:0] req_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   gnt_idx_o,
   output logic               gnt_valid_o,
   input  logic               res_ready_i,
   output logic [CNT_W-1:0]   gnt_count_o
);

   typedef enum logic {IDLE, BUSY} state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [IDX_W-1:0]   next_ptr;
   logic [IDX_W-1:0]   arb_ptr;
   logic               win_vld;
   logic [IDX_W-1:0]   win_idx;
   logic               hi_vld;
   logic [IDX_W-1:0]   hi_idx;

   // Pointer that follows the current grant; wrapped explicitly so that
   // non power-of-two NUM_REQ works.
   always_comb begin
      next_ptr = '0;
      if (gnt_idx_q != IDX_W'(NUM_REQ - 1)) begin
         next_ptr = gnt_idx_q + IDX_W'(1);
      end
   end

   // While busy the only arbitration that can take effect is on a handshake,
   // which must already see the advanced pointer; this also makes the
   // just-served requester lowest priority.
   assign arb_ptr = (state_q == BUSY) ? next_ptr : ptr_q;

   // Descending scan: the last hit written is the lowest index. hi_* tracks
   // the lowest requester at or above the pointer, win_* the lowest overall
   // (used as the wrap-around fallback).
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      hi_vld  = 1'b0;
      hi_idx  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_i[k]) begin
            win_vld = 1'b1;
            win_idx = IDX_W'(k);
            if (k >= int'(arb_ptr)) begin
               hi_vld = 1'b1;
               hi_idx = IDX_W'(k);
            end
         end
      end
      if (hi_vld) begin
         win_idx = hi_idx;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_idx_d = gnt_idx_q;
      gnt_d     = gnt_q;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d   = BUSY;
               gnt_idx_d = win_idx;
               gnt_d     = NUM_REQ'(1) << win_idx;
            end
         end
         BUSY: begin
            if (res_ready_i) begin
               cnt_d = cnt_q + CNT_W'(1);
               ptr_d = next_ptr;
               if (win_vld) begin
                  gnt_idx_d = win_idx;
                  gnt_d     = NUM_REQ'(1) << win_idx;
               end else begin
                  // Index keeps its last value when going idle.
                  state_d = IDLE;
                  gnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         gnt_idx_q <= '0;
         gnt_q     <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_idx_q <= gnt_idx_d;
         gnt_q     <= gnt_d;
         cnt_q     <= cnt_d;
      end
   end

   assign gnt_o       = gnt_q;
   assign gnt_idx_o   = gnt_idx_q;
   assign gnt_valid_o = (state_q == BUSY);
   assign gnt_count_o = cnt_q;

endmodule
